// File: rtl/xbar_req_port.sv
// xbar_req_port -- crossbar request port.
// Buffers upstream flits in a DEPTH-entry circular FIFO. The head flit's top
// DW bits select a crossbar destination. In-range heads are requested until
// granted without backpressure. Out-of-range heads are discarded for one cycle.
// Optional feature: define XBAR_REQ_STALL_CNT_EN to add the stall_cnt_o counter.
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   in_data/in_valid    upstream flit and valid
//   in_ready            FIFO has room (count_o < DEPTH)
//   data_o/dest_o       head flit and its destination (0 when empty)
//   dest_en_o           request to crossbar
//   ack_i/bp_i          same-cycle grant and destination backpressure
//   drop_o              head flit discarded this cycle
//   count_o             FIFO occupancy
//   stall_cnt_o         cycles requested without transfer (optional)
module xbar_req_port #(
   parameter int unsigned PORTS = 2,
   parameter int unsigned WIDTH = 8,
   parameter int unsigned DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic [WIDTH-1:0]         in_data,
   input  logic                     in_valid,
   output logic                     in_ready,
   output logic [WIDTH-1:0]         data_o,
   output logic [$clog2(PORTS)-1:0] dest_o,
   output logic                     dest_en_o,
   input  logic                     ack_i,
   input  logic                     bp_i,
   output logic                     drop_o,
   output logic [$clog2(DEPTH):0]   count_o
`ifdef XBAR_REQ_STALL_CNT_EN
   ,
   output logic [15:0]              stall_cnt_o
`endif
);

   localparam int unsigned DW = $clog2(PORTS);
   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned CW = AW + 1;

   typedef enum logic [1:0] {S_EMPTY, S_REQ, S_DROP} state_t;

   state_t           r_state;
   state_t           w_state_nxt;
   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [AW-1:0]    r_rd_ptr;
   logic [AW-1:0]    r_wr_ptr;
   logic [AW-1:0]    w_rd_nxt;
   logic [CW-1:0]    r_count;
   logic [CW-1:0]    w_count_nxt;
   logic             w_push;
   logic             w_pop;
   logic             w_xfer;
   logic [DW-1:0]    w_dest_nxt;

   assign in_ready = (r_count < CW'(DEPTH));
   assign w_push   = in_valid & in_ready;
   assign w_xfer   = (r_state == S_REQ) & ack_i & ~bp_i;
   assign w_pop    = w_xfer | (r_state == S_DROP);
   assign w_rd_nxt = w_pop ? r_rd_ptr + AW'(1) : r_rd_ptr;

   // Destination of the post-update head; an entry written this edge that
   // becomes the head (FIFO empty after the pop) is taken from in_data.
   assign w_dest_nxt = (w_push && (r_wr_ptr == w_rd_nxt)) ? in_data[WIDTH-1 -: DW]
                                                          : r_mem[w_rd_nxt][WIDTH-1 -: DW];

   assign data_o  = (r_count != '0) ? r_mem[r_rd_ptr] : '0;
   assign dest_o  = data_o[WIDTH-1 -: DW];
   assign count_o = r_count;

   // Occupancy update
   always_comb begin
      w_count_nxt = r_count;
      case ({w_push, w_pop})
         2'b10:   w_count_nxt = r_count + CW'(1);
         2'b01:   w_count_nxt = r_count - CW'(1);
         default: w_count_nxt = r_count;
      endcase
   end

   // State register
   always_ff @(posedge clk) begin
      if (rst) r_state <= S_EMPTY;
      else     r_state <= w_state_nxt;
   end

   // Next state from post-update contents; Moore outputs from current state
   always_comb begin
      w_state_nxt = S_EMPTY;
      dest_en_o   = 1'b0;
      drop_o      = 1'b0;
      if (w_count_nxt != '0) begin
         w_state_nxt = ({1'b0, w_dest_nxt} < (DW+1)'(PORTS)) ? S_REQ : S_DROP;
      end
      case (r_state)
         S_REQ:   dest_en_o = 1'b1;
         S_DROP:  drop_o    = 1'b1;
         default: ;
      endcase
   end

   // FIFO pointers and occupancy
   always_ff @(posedge clk) begin
      if (rst) begin
         r_rd_ptr <= '0;
         r_wr_ptr <= '0;
         r_count  <= '0;
      end else begin
         r_rd_ptr <= w_rd_nxt;
         r_count  <= w_count_nxt;
         if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      end
   end

   // FIFO storage
   always_ff @(posedge clk) begin
      if (!rst && w_push) r_mem[r_wr_ptr] <= in_data;
   end

`ifdef XBAR_REQ_STALL_CNT_EN
   logic [15:0] r_stall;

   // Saturating count of requested-but-not-transferred cycles
   always_ff @(posedge clk) begin
      if (rst)                                  r_stall <= '0;
      else if (w_xfer || (r_state == S_EMPTY))  r_stall <= '0;
      else if (dest_en_o && (r_stall != 16'hFFFF)) r_stall <= r_stall + 16'd1;
   end

   assign stall_cnt_o = r_stall;
`endif

endmodule
